// File: rtl/bash_hash_arb.sv
// bash_hash_arb: round-robin arbiter with per-requester lock that shares one hash
// control unit between two requesters, issuing prep/start and watching for completion.
module bash_hash_arb #(
    parameter int TIMEOUT = 255,
    parameter int TW      = $clog2(TIMEOUT + 1)
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] job_valid_i,
    input  logic [1:0] job_prep_i,
    input  logic [1:0] lock_i,
    output logic [1:0] job_ready_o,
    output logic [1:0] done_o,
    output logic [1:0] err_o,
    output logic       owner_o,
    output logic       busy_o,
    output logic       prep_o,
    output logic       start_o,
    input  logic       active_i,
    input  logic       rdy_i
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, ERR} state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d, last_q, last_d, lock_held_q, lock_held_d;
    logic          prep_q, prep_d, start_q, start_d, busy_q, busy_d;
    logic [1:0]    done_q, done_d, err_q, err_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [1:0]    own_oh, elig;
    logic          lock_eff, grant, g;

    // A held lock survives only while its owner keeps lock_i asserted.
    assign own_oh      = owner_q ? 2'b10 : 2'b01;
    assign lock_eff    = lock_held_q & lock_i[owner_q];
    assign elig        = job_valid_i & (lock_eff ? own_oh : 2'b11);
    assign g           = (&elig) ? ~last_q : elig[1];
    assign grant       = (state_q == IDLE) & ~active_i & (|elig);
    assign job_ready_o = grant ? (g ? 2'b10 : 2'b01) : 2'b00;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        lock_held_d = lock_held_q;
        cnt_d       = cnt_q;
        prep_d      = 1'b0;
        start_d     = 1'b0;
        done_d      = 2'b00;
        err_d       = 2'b00;
        case (state_q)
            IDLE: begin
                lock_held_d = lock_eff;
                if (grant) begin
                    owner_d = g;
                    prep_d  = job_prep_i[g];
                    start_d = ~job_prep_i[g];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + TW'(1);
                if (rdy_i) begin
                    done_d  = own_oh;
                    state_d = DONE;
                end else if (cnt_q == TW'(TIMEOUT - 1)) begin
                    err_d   = own_oh;
                    state_d = ERR;
                end
            end
            DONE: begin
                last_d      = owner_q;
                lock_held_d = lock_i[owner_q];
                state_d     = IDLE;
            end
            ERR: begin
                last_d      = owner_q;
                lock_held_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            lock_held_q <= 1'b0;
            cnt_q       <= '0;
            prep_q      <= 1'b0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 2'b00;
            err_q       <= 2'b00;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            lock_held_q <= lock_held_d;
            cnt_q       <= cnt_d;
            prep_q      <= prep_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign owner_o = owner_q;
    assign busy_o  = busy_q;
    assign prep_o  = prep_q;
    assign start_o = start_q;
    assign done_o  = done_q;
    assign err_o   = err_q;
endmodule
